// File: rtl/avst_pkt_err_filter.sv
`default_nettype none
// ============================================================================
//  Module   : avst_pkt_err_filter
//  Purpose  : Store-and-forward Avalon-ST packet buffer that only forwards
//             complete, error-free packets (errored, malformed and oversize
//             packets are discarded). Define PKTF_DROP_STATS_EN to expose the
//             drop counters and the stats_clear input.
//  Revision : 1.0 - initial release
// ============================================================================
module avst_pkt_err_filter #(
    parameter int DEPTH_LOG2 = 9,
    parameter int DATA_W     = 32
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_startofpacket,
    input  logic              in_endofpacket,
    input  logic [1:0]        in_empty,
    input  logic              in_error,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_startofpacket,
    output logic              out_endofpacket,
    output logic [1:0]        out_empty,
`ifdef PKTF_DROP_STATS_EN
    input  logic              stats_clear,
    output logic [15:0]       drop_err_cnt,
    output logic [15:0]       drop_mal_cnt,
    output logic [15:0]       drop_ovf_cnt,
`endif
    output logic              out_error
);

    localparam int                 c_PTR_W  = DEPTH_LOG2 + 1;
    localparam int                 c_DEPTH  = 1 << DEPTH_LOG2;
    localparam int                 c_WORD_W = DATA_W + 3;
    localparam logic [c_PTR_W-1:0] c_FULL   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [c_PTR_W-1:0] c_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PKT  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_cm_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic                r_in_ready;
    logic [c_WORD_W-1:0] r_mem [c_DEPTH];
    logic [c_WORD_W-1:0] r_s1_word;
    logic                r_s1_vld;
    logic                r_next_sop;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_out_sop;
    logic                r_out_eop;
    logic [1:0]          r_out_empty;

    logic                w_accept;
    logic                w_in_pkt;
    logic                w_pkt_beat;
    logic                w_full;
    logic                w_store;
    logic                w_s1_load;
    logic                w_s2_load;
    logic [c_PTR_W-1:0]  w_wr_base;
    logic [c_PTR_W-1:0]  w_wr_next;

`ifdef PKTF_DROP_STATS_EN
    logic [15:0] r_drop_err_cnt;
    logic [15:0] r_drop_mal_cnt;
    logic [15:0] r_drop_ovf_cnt;

    function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign drop_err_cnt = r_drop_err_cnt;
    assign drop_mal_cnt = r_drop_mal_cnt;
    assign drop_ovf_cnt = r_drop_ovf_cnt;
`endif

    assign w_accept   = in_valid && r_in_ready;
    assign w_in_pkt   = (r_state == S_PKT);
    assign w_pkt_beat = in_startofpacket || w_in_pkt;
    // Any SOP restarts from the committed pointer, discarding an unfinished packet
    assign w_wr_base  = (w_in_pkt && !in_startofpacket) ? r_wr_ptr : r_cm_ptr;
    assign w_wr_next  = w_wr_base + c_ONE;
    assign w_full     = ((w_wr_base - r_rd_ptr) == c_FULL);
    assign w_store    = w_accept && w_pkt_beat && !w_full;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_cm_ptr   <= '0;
            r_in_ready <= 1'b0;
`ifdef PKTF_DROP_STATS_EN
            r_drop_err_cnt <= '0;
            r_drop_mal_cnt <= '0;
            r_drop_ovf_cnt <= '0;
`endif
        end else begin
            r_in_ready <= 1'b1;
            if (w_accept) begin
                if (w_pkt_beat) begin
`ifdef PKTF_DROP_STATS_EN
                    if (w_in_pkt && in_startofpacket)
                        r_drop_mal_cnt <= f_sat_inc(r_drop_mal_cnt);
`endif
                    if (w_full) begin
                        r_wr_ptr <= r_cm_ptr;
                        r_state  <= in_endofpacket ? S_IDLE : S_DROP;
`ifdef PKTF_DROP_STATS_EN
                        r_drop_ovf_cnt <= f_sat_inc(r_drop_ovf_cnt);
`endif
                    end else if (in_endofpacket) begin
                        r_state <= S_IDLE;
                        if (in_error) begin
                            r_wr_ptr <= r_cm_ptr;
`ifdef PKTF_DROP_STATS_EN
                            r_drop_err_cnt <= f_sat_inc(r_drop_err_cnt);
`endif
                        end else begin
                            r_wr_ptr <= w_wr_next;
                            r_cm_ptr <= w_wr_next;
                        end
                    end else begin
                        r_wr_ptr <= w_wr_next;
                        r_state  <= S_PKT;
                    end
                end else if (in_endofpacket) begin
                    r_state <= S_IDLE;
                end
            end
`ifdef PKTF_DROP_STATS_EN
            if (stats_clear) begin
                r_drop_err_cnt <= '0;
                r_drop_mal_cnt <= '0;
                r_drop_ovf_cnt <= '0;
            end
`endif
        end
    end

    // Two-stage read pipe: RAM read register feeding the output register
    assign w_s2_load = r_s1_vld && (!r_out_valid || out_ready);
    assign w_s1_load = (r_rd_ptr != r_cm_ptr) && (!r_s1_vld || w_s2_load);

    always_ff @(posedge clk_clk) begin
        if (w_store)
            r_mem[w_wr_base[DEPTH_LOG2-1:0]] <= {in_data, in_endofpacket, in_empty};
        if (w_s1_load)
            r_s1_word <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rd_ptr    <= '0;
            r_s1_vld    <= 1'b0;
            r_next_sop  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_empty <= '0;
        end else begin
            if (w_s1_load) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
                r_s1_vld <= 1'b1;
            end else if (w_s2_load) begin
                r_s1_vld <= 1'b0;
            end
            if (w_s2_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_s1_word[c_WORD_W-1 -: DATA_W];
                r_out_eop   <= r_s1_word[2];
                r_out_empty <= r_s1_word[1:0];
                r_out_sop   <= r_next_sop;
                r_next_sop  <= r_s1_word[2];
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready          = r_in_ready;
    assign out_data          = r_out_data;
    assign out_valid         = r_out_valid;
    assign out_startofpacket = r_out_sop;
    assign out_endofpacket   = r_out_eop;
    assign out_empty         = r_out_empty;
    assign out_error         = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_avst_pkt_err_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_avst_pkt_err_filter
//  Purpose  : Self-checking bench for avst_pkt_err_filter (DEPTH_LOG2=4) with
//             a packet-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_avst_pkt_err_filter;

    localparam int c_DL2   = 4;
    localparam int c_DEPTH = 1 << c_DL2;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [31:0] in_data  = '0;
    logic        in_valid = 1'b0;
    logic        in_sop   = 1'b0;
    logic        in_eop   = 1'b0;
    logic [1:0]  in_empty = '0;
    logic        in_err   = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic [1:0]  out_empty;
    logic        out_error;
`ifdef PKTF_DROP_STATS_EN
    logic        stats_clear = 1'b0;
    logic [15:0] drop_err_cnt;
    logic [15:0] drop_mal_cnt;
    logic [15:0] drop_ovf_cnt;
`endif

    always #5 clk = ~clk;

    avst_pkt_err_filter #(.DEPTH_LOG2(c_DL2), .DATA_W(32)) dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_startofpacket  (in_sop),
        .in_endofpacket    (in_eop),
        .in_empty          (in_empty),
        .in_error          (in_err),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .out_empty         (out_empty),
`ifdef PKTF_DROP_STATS_EN
        .stats_clear       (stats_clear),
        .drop_err_cnt      (drop_err_cnt),
        .drop_mal_cnt      (drop_mal_cnt),
        .drop_ovf_cnt      (drop_ovf_cnt),
`endif
        .out_error         (out_error)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } word_t;

    word_t exp_q[$];
    word_t mon_w;
    int    vec_cnt    = 0;
    int    err_cnt    = 0;
    int    exp_err    = 0;
    int    exp_mal    = 0;
    int    exp_ovf    = 0;
    bit    in_partial = 1'b0;
    int    rdy_mode   = 3;   // 0 always ready, 1 toggle, 2 random, 3 stalled

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                2:       out_ready = (($urandom % 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: in-order scoreboard plus hold-while-stalled check
    logic        prev_stall = 1'b0;
    logic [36:0] held       = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {out_valid, out_sop, out_eop, out_empty, out_data}, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", out_valid, 1'b0);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("data", out_data, mon_w.data);
                    check("sop", out_sop, mon_w.sop);
                    check("eop", out_eop, mon_w.eop);
                    if (mon_w.eop)
                        check("empty", out_empty, mon_w.empty);
                    check("error", out_error, 1'b0);
                end
            end
            prev_stall = out_valid && !out_ready;
            held       = {out_valid, out_sop, out_eop, out_empty, out_data};
        end
    end

    task automatic drive_beat(input logic [31:0] d, input logic s, input logic e,
                              input logic [1:0] emp, input logic er, input int gap_pct);
        while (gap_pct > 0 && int'($urandom % 100) < gap_pct) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        in_empty = emp;
        in_err   = er;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_err   = 1'b0;
    endtask

    // Wait until a packet of len words is guaranteed to fit behind the pending words
    task automatic wait_space(input int len);
        int n = 0;
        bit waited = 1'b0;
        while (exp_q.size() + len > c_DEPTH && n < 4000) begin
            @(negedge clk);
            n++;
            waited = 1'b1;
        end
        if (n >= 4000)
            check("space_timeout", 64'(exp_q.size()), 64'd0);
        if (waited) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(input int len, input bit err, input bit seq,
                            input logic [1:0] last_empty, input int gap_pct);
        word_t w[$];
        logic [31:0] d;
        bit last;
        if (len <= c_DEPTH)
            wait_space(len);
        for (int i = 0; i < len; i++) begin
            d    = seq ? 32'(32'h11 * (i + 1)) : $urandom;
            last = (i == len - 1);
            drive_beat(d, (i == 0), last, last ? last_empty : 2'($urandom),
                       last ? err : 1'($urandom), gap_pct);
            w.push_back('{data: d, sop: (i == 0), eop: last, empty: last_empty});
        end
        if (in_partial)
            exp_mal++;
        in_partial = 1'b0;
        if (len > c_DEPTH)
            exp_ovf++;
        else if (err)
            exp_err++;
        else
            foreach (w[i]) exp_q.push_back(w[i]);
    endtask

    task automatic send_partial(input int k, input int gap_pct);
        wait_space(k);
        for (int i = 0; i < k; i++)
            drive_beat($urandom, (i == 0), 1'b0, 2'($urandom), 1'($urandom), gap_pct);
        in_partial = 1'b1;
    endtask

    task automatic send_stray(input int n);
        for (int i = 0; i < n; i++)
            drive_beat($urandom, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom), 0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check(tag, 64'(exp_q.size()), 64'd0);
        check({tag, "_idle"}, out_valid, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int roll;
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_sop_eop", {out_sop, out_eop, out_empty}, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", in_ready, 1'b1);

        // Clean 4-beat packet and output latency
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_pkt(4, 1'b0, 1'b1, 2'd2, 0);
        @(negedge clk);
        check("lat_cycle0", out_valid, 1'b0);
        @(negedge clk);
        check("lat_cycle1", out_valid, 1'b0);
        @(negedge clk);
        check("lat_cycle2", out_valid, 1'b1);
        drain("drain_clean");

        // Errored packet then clean packet
        send_pkt(6, 1'b1, 1'b0, 2'd1, 0);
        send_pkt(3, 1'b0, 1'b0, 2'd0, 0);
        drain("drain_err");

        // Oversize then exactly-full packet
        send_pkt(17, 1'b0, 1'b1, 2'd3, 0);
        send_pkt(16, 1'b0, 1'b1, 2'd1, 0);
        drain("drain_ovf");

        // Malformed: SOP after two beats of an unfinished packet
        send_partial(2, 0);
        send_pkt(3, 1'b0, 1'b0, 2'd2, 0);
        drain("drain_mal");

        // Backpressure with ready toggling every cycle
        rdy_mode = 1;
        send_pkt(5, 1'b0, 1'b0, 2'd1, 0);
        send_pkt(5, 1'b0, 1'b0, 2'd3, 0);
        drain("drain_bp");
        rdy_mode = 0;

`ifdef PKTF_DROP_STATS_EN
        check("cnt_err", drop_err_cnt, 16'(exp_err));
        check("cnt_mal", drop_mal_cnt, 16'(exp_mal));
        check("cnt_ovf", drop_ovf_cnt, 16'(exp_ovf));
        @(posedge clk);
        #1;
        stats_clear = 1'b1;
        @(posedge clk);
        #1;
        stats_clear = 1'b0;
        check("cnt_clear", {drop_err_cnt, drop_mal_cnt, drop_ovf_cnt}, 48'd0);
        exp_err = 0;
        exp_mal = 0;
        exp_ovf = 0;
`endif

        // Reset mid-packet with committed packets pending
        rdy_mode = 3;
        @(posedge clk);
        #1;
        send_pkt(3, 1'b0, 1'b0, 2'd0, 0);
        send_pkt(3, 1'b0, 1'b0, 2'd0, 0);
        send_partial(3, 0);
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_flags", {out_sop, out_eop, out_empty, out_error}, 5'd0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        exp_q.delete();
        in_partial = 1'b0;
        exp_err = 0;
        exp_mal = 0;
        exp_ovf = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_empty", out_valid, 1'b0);
        send_pkt(4, 1'b0, 1'b1, 2'd2, 0);
        drain("drain_post_rst");

        // Randomized traffic
        rdy_mode = 2;
        for (int p = 0; p < 80; p++) begin
            roll = int'($urandom % 100);
            if (roll < 10) begin
                send_pkt(int'($urandom_range(1, 12)), 1'b1, 1'b0, 2'($urandom), 20);
            end else if (roll < 18) begin
                send_partial(int'($urandom_range(1, 5)), 20);
                send_pkt(int'($urandom_range(1, 8)), 1'b0, 1'b0, 2'($urandom), 20);
            end else if (roll < 22) begin
                send_pkt(int'($urandom_range(17, 20)), 1'($urandom), 1'b0, 2'($urandom), 20);
            end else if (roll < 28) begin
                send_stray(int'($urandom_range(1, 3)));
            end else begin
                send_pkt(int'($urandom_range(1, 16)), 1'b0, 1'b0, 2'($urandom), 20);
            end
        end
        drain("drain_random");
`ifdef PKTF_DROP_STATS_EN
        check("rnd_cnt_err", drop_err_cnt, 16'(exp_err));
        check("rnd_cnt_mal", drop_mal_cnt, 16'(exp_mal));
        check("rnd_cnt_ovf", drop_ovf_cnt, 16'(exp_ovf));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/avst_pkt_err_filter.md
Name: avst_pkt_err_filter

Overview:
- Single-clock store-and-forward packet buffer placed directly downstream of the dual-clock Avalon-ST FIFO, in its output clock domain.
- Accepts 32-bit Avalon-ST packets (sop/eop/empty/error).
- Releases a packet downstream only after its EOP is stored error-free.
- Discards errored, malformed and oversize packets so downstream logic only ever sees clean, complete frames.

Parameters:
- DEPTH_LOG2, 9, log2 of buffer depth in 35-bit words (data + eop + empty); default depth is 512 words.
- DATA_W, 32, data width; fixed at 32, empty width is 2.

Ports:
- clk_clk  in  1  single clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- in_data  in  32  sink data.
- in_valid  in  1  sink valid.
- in_ready  out  1  sink ready; constant 1 once out of reset, never backpressures.
- in_startofpacket  in  1  sink SOP.
- in_endofpacket  in  1  sink EOP.
- in_empty  in  2  empty bytes on EOP beat.
- in_error  in  1  error flag, sampled on the EOP beat only.
- out_data  out  32  source data.
- out_valid  out  1  source valid.
- out_ready  in  1  source ready, ready latency 0.
- out_startofpacket  out  1  source SOP.
- out_endofpacket  out  1  source EOP.
- out_empty  out  2  source empty, meaningful on EOP beat only.
- out_error  out  1  always 0.

Behaviour:
- Reset (async assert, sync deassert):
  - All pointers 0, write FSM in IDLE.
  - in_ready=0 while reset is asserted, 1 from the first clock after deassertion.
  - All out_* = 0.
- Pointers are DEPTH_LOG2+1 bits and wrap modulo 2^(DEPTH_LOG2+1):
  - wr_ptr: speculative write pointer.
  - cm_ptr: committed write pointer.
  - rd_ptr: read pointer.
  - full when wr_ptr - rd_ptr == 2^DEPTH_LOG2.
- Write FSM, a beat is accepted when in_valid=1:
  - IDLE:
    - Beat without SOP: discarded, stay IDLE.
    - SOP beat: write it, go PKT.
    - SOP+EOP on the same beat: write it, then commit or discard as below, stay IDLE.
  - PKT:
    - Each beat is written at wr_ptr, then wr_ptr++.
    - EOP with in_error=0: cm_ptr <= wr_ptr+1, go IDLE.
    - EOP with in_error=1: wr_ptr <= cm_ptr, drop_err_cnt++, go IDLE.
    - SOP without EOP (malformed): rewind wr_ptr to cm_ptr, write this beat as the start of a new packet, stay PKT, drop_mal_cnt++.
    - Beat arrives while full: rewind wr_ptr to cm_ptr, go DROP, drop_ovf_cnt++.
  - DROP:
    - Discard beats until an EOP beat, then go IDLE.
    - A SOP beat in DROP starts a new packet as in IDLE.
- Any packet longer than 2^DEPTH_LOG2 words is always dropped; a packet of exactly 2^DEPTH_LOG2 words into an empty buffer is accepted.
- Read side, show-ahead with a registered output stage:
  - Words become readable when rd_ptr != cm_ptr.
  - out_valid asserts exactly 2 cycles after the commit edge when the buffer and output stage are empty (1 cycle RAM read, 1 cycle output register).
  - Output advances when out_valid && out_ready.
  - Sustains 1 word/cycle with out_ready held high.
  - out_startofpacket=1 on the first word after reset or after a word carrying eop; regenerated on the read side, not stored.
  - out_data/out_empty/out_endofpacket hold stable while out_valid=1 && out_ready=0.
- Simultaneous events:
  - A commit and a read in the same cycle are both honoured.
  - A rewind never moves below rd_ptr, because cm_ptr >= rd_ptr always holds.
- Counters (drop_*_cnt) are 16-bit saturating, internal unless the optional feature is enabled.

Optional Feature:
- Macro PKTF_DROP_STATS_EN.
- Defined:
  - Adds output ports drop_err_cnt, drop_mal_cnt and drop_ovf_cnt (16 each, saturating at 0xFFFF) and input stats_clear (1).
  - A stats_clear pulse zeroes all three counters on the next edge; it takes priority over a simultaneous increment.
- Undefined: the counters and ports are absent and drop behaviour is unchanged.

Test Plan:
- Clean 4-beat packet (data 0x11..0x44, empty=2 on EOP), out_ready=1:
  - out_valid rises 2 cycles after the EOP beat.
  - 4 beats out with SOP on 0x11, EOP+empty=2 on 0x44, out_error=0.
- Errored packet (6 beats, error=1 on EOP) followed by a clean 3-beat packet:
  - Only the 3-beat packet appears.
  - drop_err_cnt=1.
- Oversize packet, DEPTH_LOG2=4, 17 beats: nothing is output, drop_ovf_cnt=1. A following 16-beat packet is output intact.
- SOP after beat 2 of an unfinished packet, then a 3-beat clean packet: only the 3-beat packet is output, drop_mal_cnt=1.
- Backpressure:
  - Two 5-beat packets with out_ready toggling 1/0 each cycle.
  - All 10 words out in order, data stable while stalled, exactly two SOP/EOP pairs.
- Reset asserted mid-packet (beat 3 of 8) with 2 committed packets pending:
  - All out_* = 0 immediately.
  - After release the buffer is empty and a new packet passes normally.
